decode_stage_fifo: RTL and testbench
====================================

// Module: decode_stage_fifo
// PURPOSE
//  Parametrised decode stage: elastic FIFO of DEPTH fetch packets (PC, instr) between fetch and execute.
//  Replaces the single-register decode stage; adds backpressure (in_ready), buffering, flush and field decode.
//  Output head carries the raw packet plus RV32 base fields, so execute needs no slicing logic.
// PARAMETERS
//  ADDR_W   32  PC width in bits
//  INSTR_W  32  instruction width in bits; must be >= 32 (elaboration error otherwise)
//  DEPTH    2   FIFO entries; power of 2, >= 2
//  CNT_W    16  width of stall_cycles counter
// PORTS
//  clk                 in   1              rising-edge clock
//  reset_n             in   1              asynchronous reset, active-low
//  PC_in               in   ADDR_W         fetched PC
//  instr_in            in   INSTR_W        fetched instruction
//  pipeline_in_valid   in   1              PC_in/instr_in valid
//  in_ready            out  1              stage can accept a packet this cycle
//  PC_out              out  ADDR_W         PC of head entry
//  instr_out           out  INSTR_W        instruction of head entry
//  opcode_out          out  7              instr_out[6:0]
//  rd_out              out  5              instr_out[11:7]
//  funct3_out          out  3              instr_out[14:12]
//  rs1_out             out  5              instr_out[19:15]
//  rs2_out             out  5              instr_out[24:20]
//  illegal_out         out  1              instr_out[1:0] != 2'b11 (not a 32-bit encoding)
//  pipeline_out_valid  out  1              head entry valid
//  stall               in   1              downstream not accepting head this cycle
//  flush               in   1              discard all buffered and incoming packets
//  count               out  $clog2(DEPTH)+1  entries held
//  stall_cycles        out  CNT_W          cycles with pipeline_out_valid && stall, saturating
// BEHAVIOUR
//  Reset (reset_n=0, async): wr/rd pointers=0, count=0, pipeline_out_valid=0, in_ready=1,
//   storage=0 (so PC_out/instr_out/decoded fields=0, illegal_out=1), stall_cycles=0.
//  in_ready = (count != DEPTH); combinational from count only, not from stall (no bypass).
//  Enqueue at edge when pipeline_in_valid && in_ready && !flush; write at wr_ptr, wr_ptr+1 (mod DEPTH).
//  pipeline_out_valid = (count != 0). Head outputs read combinationally from storage[rd_ptr].
//  Dequeue at edge when pipeline_out_valid && !stall && !flush; rd_ptr+1 (mod DEPTH).
//  Latency: packet enqueued at edge N is visible on outputs after edge N if FIFO was empty.
//  Simultaneous enqueue+dequeue: count unchanged, both pointers advance; legal at any count < DEPTH.
//  Full (count==DEPTH): in_ready=0, input ignored even if pipeline_in_valid; dequeue still allowed.
//  Empty: head outputs show storage[rd_ptr] (stale); consumers must qualify with pipeline_out_valid.
//  Pointer wrap: DEPTH-1 -> 0; ordering strictly FIFO across wrap.
//  Flush (sync, highest priority after reset): at edge, pointers=0, count=0; packet presented
//   that cycle is dropped; storage not cleared; stall_cycles unaffected.
//  Flush and stall together: flush wins. Reset mid-operation: immediate clear, in-flight packets lost.
//  stall_cycles increments at edge when pipeline_out_valid && stall; holds at 2^CNT_W-1.
//  Decoded fields are pure slices of instr_out; no registered copy, zero added latency.
// TESTING
//  Reset: reset_n=0 mid-stream with count=2 -> outputs at reset values without clock edge.
//  Pass-through: push PC=0x100 instr=0x00A28293 one cycle, stall=0 -> next cycle valid=1,
//   opcode=0x13 rd=5 funct3=0 rs1=5 rs2=10, then valid=0.
//  Fill: stall=1, push 0x100,0x104,0x108 (DEPTH=2) -> count=2, in_ready=0, 0x108 dropped;
//   release stall -> outputs 0x100 then 0x104; stall_cycles equals stalled valid cycles.
//  Wrap: stream 8 packets PC=0x0..0x1C with random stall, DEPTH=4 -> output order 0x0..0x1C exact.
//  Flush: count=2, flush=1 with pipeline_in_valid=1 PC=0x200 -> next cycle count=0, valid=0, 0x200 absent.
//  Illegal: push instr=0x00000001 -> illegal_out=1; instr=0x00000013 -> illegal_out=0.

Source files
------------

// File: rtl/decode_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_fifo
//  Description : Elastic decode stage. A DEPTH-entry FIFO of fetch packets
//                (PC, instruction) sits between fetch and execute, providing
//                backpressure, buffering, and flush. The head entry is also
//                presented as RV32 base-format fields, so execute needs no
//                slicing logic of its own.
//  Ports       : clk, reset_n             clock / async active-low reset
//                PC_in, instr_in          incoming fetch packet
//                pipeline_in_valid        incoming packet valid
//                in_ready                 stage can accept a packet this cycle
//                PC_out, instr_out        head packet
//                opcode_out .. rs2_out    RV32 fields sliced from instr_out
//                illegal_out              head is not a 32-bit encoding
//                pipeline_out_valid       head entry valid
//                stall                    downstream refuses head this cycle
//                flush                    discard buffered and incoming packets
//                count                    entries held
//                stall_cycles             saturating count of stalled-valid cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_fifo #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          PC_in,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic                       pipeline_in_valid,
    output logic                       in_ready,
    output logic [ADDR_W-1:0]          PC_out,
    output logic [INSTR_W-1:0]         instr_out,
    output logic [6:0]                 opcode_out,
    output logic [4:0]                 rd_out,
    output logic [2:0]                 funct3_out,
    output logic [4:0]                 rs1_out,
    output logic [4:0]                 rs2_out,
    output logic                       illegal_out,
    output logic                       pipeline_out_valid,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(DEPTH);

    // Parameter legality is checked at elaboration time.
    generate
        if (INSTR_W < 32) begin : g_bad_instr_w
            $error("decode_stage_fifo: INSTR_W must be >= 32");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("decode_stage_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic w_enq;
    logic w_deq;

    // Ready depends only on occupancy: a full FIFO refuses input even when
    // the head is leaving this cycle, so there is no ready path from stall.
    assign in_ready           = (r_count != c_FULL);
    assign pipeline_out_valid = (r_count != '0);

    // Flush overrides both handshakes.
    assign w_enq = pipeline_in_valid && in_ready && !flush;
    assign w_deq = pipeline_out_valid && !stall && !flush;

    // Storage and pointers. Pointers wrap naturally since DEPTH is a power of 2.
    // Flush rewinds the pointers but leaves storage contents in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) begin
                r_pc_mem[r_wr_ptr]    <= PC_in;
                r_instr_mem[r_wr_ptr] <= instr_in;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    // Occupancy: unchanged on simultaneous enqueue and dequeue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Performance counter: counts every cycle a valid head is held by stall,
    // independent of flush, and sticks at its maximum value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (pipeline_out_valid && stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign count        = r_count;
    assign stall_cycles = r_stall_cycles;

    // Head is read combinationally; when empty it shows stale storage.
    assign PC_out    = r_pc_mem[r_rd_ptr];
    assign instr_out = r_instr_mem[r_rd_ptr];

    // RV32 base fields are pure slices of the head instruction.
    assign opcode_out  = instr_out[6:0];
    assign rd_out      = instr_out[11:7];
    assign funct3_out  = instr_out[14:12];
    assign rs1_out     = instr_out[19:15];
    assign rs2_out     = instr_out[24:20];
    assign illegal_out = (instr_out[1:0] != 2'b11);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_fifo
//  Description : Self-checking bench for decode_stage_fifo. Drives a DEPTH=2
//                and a DEPTH=4 instance from shared stimulus; each check
//                targets the instance whose depth the scenario needs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] PC_in;
    logic [31:0] instr_in;
    logic        pipeline_in_valid;
    logic        stall;
    logic        flush;

    // DEPTH=2 instance outputs
    logic        a_in_ready, a_valid, a_illegal;
    logic [31:0] a_pc, a_instr;
    logic [6:0]  a_opcode;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3;
    logic [1:0]  a_count;
    logic [15:0] a_sc;

    // DEPTH=4 instance outputs
    logic        b_in_ready, b_valid, b_illegal;
    logic [31:0] b_pc, b_instr;
    logic [6:0]  b_opcode;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic [2:0]  b_count;
    logic [15:0] b_sc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage_fifo #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .reset_n(reset_n), .PC_in(PC_in), .instr_in(instr_in),
        .pipeline_in_valid(pipeline_in_valid), .in_ready(a_in_ready),
        .PC_out(a_pc), .instr_out(a_instr), .opcode_out(a_opcode), .rd_out(a_rd),
        .funct3_out(a_funct3), .rs1_out(a_rs1), .rs2_out(a_rs2),
        .illegal_out(a_illegal), .pipeline_out_valid(a_valid), .stall(stall),
        .flush(flush), .count(a_count), .stall_cycles(a_sc)
    );

    decode_stage_fifo #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .CNT_W(16)) u_d4 (
        .clk(clk), .reset_n(reset_n), .PC_in(PC_in), .instr_in(instr_in),
        .pipeline_in_valid(pipeline_in_valid), .in_ready(b_in_ready),
        .PC_out(b_pc), .instr_out(b_instr), .opcode_out(b_opcode), .rd_out(b_rd),
        .funct3_out(b_funct3), .rs1_out(b_rs1), .rs2_out(b_rs2),
        .illegal_out(b_illegal), .pipeline_out_valid(b_valid), .stall(stall),
        .flush(flush), .count(b_count), .stall_cycles(b_sc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl);
        pipeline_in_valid = v;
        PC_in             = pc;
        instr_in          = ins;
        stall             = st;
        flush             = fl;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    typedef struct {
        logic        vin;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        e_valid;
        logic [1:0]  e_count;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [15:0] e_sc;
    } vec_t;

    function automatic vec_t mk(input logic vin, input logic [31:0] pc, input logic st,
                                input logic fl, input logic ev, input logic [1:0] ec,
                                input logic er, input logic [31:0] epc, input logic [15:0] esc);
        vec_t v;
        v.vin = vin; v.pc = pc; v.stall = st; v.flush = fl;
        v.e_valid = ev; v.e_count = ec; v.e_ready = er; v.e_pc = epc; v.e_sc = esc;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int sent;
        int recv;
        int cyc;
        logic hs;

        //           vin pc       st fl  valid cnt rdy pc_out   sc
        tbl[0]  = mk(1, 32'h100, 1, 0,  1, 2'd1, 1, 32'h100, 16'd0);
        tbl[1]  = mk(1, 32'h104, 1, 0,  1, 2'd2, 0, 32'h100, 16'd1);
        tbl[2]  = mk(1, 32'h108, 1, 0,  1, 2'd2, 0, 32'h100, 16'd2);
        tbl[3]  = mk(0, 32'h0,   0, 0,  1, 2'd1, 1, 32'h104, 16'd2);
        tbl[4]  = mk(0, 32'h0,   0, 0,  0, 2'd0, 1, 32'h0,   16'd2);
        tbl[5]  = mk(1, 32'h10C, 0, 0,  1, 2'd1, 1, 32'h10C, 16'd2);
        tbl[6]  = mk(1, 32'h110, 0, 0,  1, 2'd1, 1, 32'h110, 16'd2);
        tbl[7]  = mk(1, 32'h114, 1, 0,  1, 2'd2, 0, 32'h110, 16'd3);
        tbl[8]  = mk(1, 32'h118, 0, 0,  1, 2'd1, 1, 32'h114, 16'd3);
        tbl[9]  = mk(1, 32'h11C, 1, 0,  1, 2'd2, 0, 32'h114, 16'd4);
        tbl[10] = mk(1, 32'h200, 0, 1,  0, 2'd0, 1, 32'h0,   16'd4);
        tbl[11] = mk(1, 32'h120, 0, 0,  1, 2'd1, 1, 32'h120, 16'd4);
        tbl[12] = mk(0, 32'h0,   0, 0,  0, 2'd0, 1, 32'h0,   16'd4);

        // ---- reset state, before any clock edge ----
        reset_n = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        #2;
        chk("rst_valid",   a_valid,   1'b0);
        chk("rst_ready",   a_in_ready, 1'b1);
        chk("rst_count",   a_count,   2'd0);
        chk("rst_pc",      a_pc,      32'h0);
        chk("rst_instr",   a_instr,   32'h0);
        chk("rst_illegal", a_illegal, 1'b1);
        chk("rst_sc",      a_sc,      16'd0);
        step();
        reset_n = 1'b1;

        // ---- pass-through with field decode ----
        drive(1, 32'h100, 32'h00A28293, 0, 0);
        step();
        chk("pt_valid",   a_valid,   1'b1);
        chk("pt_pc",      a_pc,      32'h100);
        chk("pt_opcode",  a_opcode,  7'h13);
        chk("pt_rd",      a_rd,      5'd5);
        chk("pt_funct3",  a_funct3,  3'd0);
        chk("pt_rs1",     a_rs1,     5'd5);
        chk("pt_rs2",     a_rs2,     5'd10);
        chk("pt_illegal", a_illegal, 1'b0);
        drive(0, 32'h0, 32'h0, 0, 0);
        step();
        chk("pt_drain_valid", a_valid, 1'b0);

        // ---- illegal encoding flag ----
        drive(1, 32'h140, 32'h00000001, 0, 0);
        step();
        chk("ill_valid",  a_valid,   1'b1);
        chk("ill_set",    a_illegal, 1'b1);
        drive(1, 32'h144, 32'h00000013, 0, 0);
        step();
        chk("ill_pc",     a_pc,      32'h144);
        chk("ill_clear",  a_illegal, 1'b0);
        drive(0, 32'h0, 32'h0, 0, 0);
        step();
        chk("ill_drain",  a_valid,   1'b0);

        // ---- table: fill, drop when full, drain, enq+deq, flush ----
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vin, tbl[i].pc, ins_of(tbl[i].pc), tbl[i].stall, tbl[i].flush);
            step();
            chk($sformatf("tbl%0d_valid", i), a_valid,    tbl[i].e_valid);
            chk($sformatf("tbl%0d_count", i), a_count,    tbl[i].e_count);
            chk($sformatf("tbl%0d_ready", i), a_in_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_sc", i),    a_sc,       tbl[i].e_sc);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i),    a_pc,    tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), a_instr, ins_of(tbl[i].e_pc));
            end
        end

        // ---- wrap with random stall on DEPTH=4 ----
        drive(0, 32'h0, 32'h0, 0, 1);
        step();
        chk("wrap_pre_count", b_count, 3'd0);
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 8 && cyc < 300) begin
            drive(sent < 8, 32'(sent * 4), 32'h00000013, 1'($urandom_range(0, 1)), 0);
            #1;
            hs = pipeline_in_valid && b_in_ready;
            if (b_valid && !stall) begin
                chk("wrap_order", b_pc, 64'(recv * 4));
                recv++;
            end
            if (hs) sent++;
            step();
            cyc++;
        end
        chk("wrap_received", 64'(recv), 64'd8);
        chk("wrap_empty", b_count, 3'd0);

        // ---- fill DEPTH=4 to capacity ----
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 32'h00000013, 1, 0);
            step();
        end
        chk("full4_count", b_count,    3'd4);
        chk("full4_ready", b_in_ready, 1'b0);
        chk("full4_head",  b_pc,       32'h300);
        drive(0, 32'h0, 32'h0, 0, 1);
        step();
        chk("full4_flush", b_count, 3'd0);

        // ---- asynchronous reset mid-stream ----
        drive(1, 32'h400, 32'h00000013, 1, 0);
        step();
        drive(1, 32'h404, 32'h00000013, 1, 0);
        step();
        chk("arst_pre_count", a_count, 2'd2);
        drive(0, 32'h0, 32'h0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_count",   a_count,    2'd0);
        chk("arst_valid",   a_valid,    1'b0);
        chk("arst_ready",   a_in_ready, 1'b1);
        chk("arst_pc",      a_pc,       32'h0);
        chk("arst_illegal", a_illegal,  1'b1);
        chk("arst_sc",      a_sc,       16'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
